// File: rtl/xy_div_pkg.sv
// xy_div_pkg: shared register addresses, control/status bit positions and FSM states
package xy_div_pkg;

    localparam logic [1:0] A_X    = 2'd0;
    localparam logic [1:0] A_Y    = 2'd1;
    localparam logic [1:0] A_RES  = 2'd2;
    localparam logic [1:0] A_CTRL = 2'd3;

    localparam int C_START = 0;
    localparam int C_CLR   = 1;
    localparam int C_IE    = 2;

    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_DBZ  = 2;
    localparam int ST_IE   = 3;

    typedef enum logic {S_IDLE, S_RUN} state_t;

endpackage

// File: rtl/div_core.sv
// div_core: restoring shift/subtract divider, one quotient bit per step
module div_core #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             last,
    output logic [WIDTH-1:0] quo_nx,
    output logic [WIDTH-1:0] rem_nx
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] rem_q, quo_q, div_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   trial;
    logic             fit;

    // The dividend shifts out of the top of quo_q while quotient bits enter at the bottom
    always_comb begin
        trial  = {rem_q, quo_q[WIDTH-1]} - {1'b0, div_q};
        fit    = !trial[WIDTH];
        rem_nx = fit ? trial[WIDTH-1:0] : {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
        quo_nx = {quo_q[WIDTH-2:0], fit};
        last   = cnt_q == CW'(WIDTH - 1);
    end

    // Datapath registers: snapshot operands on load, advance one bit per step
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rem_q <= '0;
            quo_q <= '0;
            div_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= x;
            div_q <= y;
            cnt_q <= '0;
        end else if (step) begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/xy_divide_seq.sv
// xy_divide_seq: memory-mapped sequential unsigned divider with status and interrupt
module xy_divide_seq
    import xy_div_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int OUT_W = 2 * WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             E,
    input  logic             W,
    input  logic             R,
    input  logic [1:0]       ADDR,
    input  logic [WIDTH-1:0] D,
    output logic [OUT_W-1:0] OUT,
    output logic             IRQ
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d, quo_q, quo_d, rem_q, rem_d;
    logic             busy_q, busy_d, done_q, done_d, dbz_q, dbz_d, ie_q, ie_d, irq_q, irq_d;
    logic [OUT_W-1:0] out_q, out_d, rd_data;
    logic             wr, rd, ctrl_wr, start, load, step, last;
    logic [WIDTH-1:0] core_quo, core_rem;

    div_core #(.WIDTH(WIDTH)) u_core (
        .CLK    (CLK),
        .RST    (RST),
        .load   (load),
        .step   (step),
        .x      (x_q),
        .y      (y_q),
        .last   (last),
        .quo_nx (core_quo),
        .rem_nx (core_rem)
    );

    // Read mux sees only pre-edge register values, so a same-cycle write is not visible
    always_comb begin
        rd_data = ADDR == A_X   ? OUT_W'(x_q) :
                  ADDR == A_Y   ? OUT_W'(y_q) :
                  ADDR == A_RES ? OUT_W'({rem_q, quo_q}) :
                                  OUT_W'({ie_q, dbz_q, done_q, busy_q});
    end

    // Bus decode, register file, FSM next state, status and interrupt
    always_comb begin
        wr      = E && W;
        rd      = E && R;
        ctrl_wr = wr && ADDR == A_CTRL;
        start   = ctrl_wr && D[C_START];
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        busy_d  = busy_q;
        done_d  = done_q;
        dbz_d   = dbz_q;
        ie_d    = ie_q;
        out_d   = rd ? rd_data : out_q;
        load    = 1'b0;
        step    = 1'b0;
        if (wr && ADDR == A_X && !busy_q) x_d = D;
        if (wr && ADDR == A_Y && !busy_q) y_d = D;
        if (ctrl_wr) ie_d = D[C_IE];
        if (ctrl_wr && D[C_CLR]) done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && y_q != '0) begin
                    state_d = S_RUN;
                    load    = 1'b1;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    dbz_d   = 1'b0;
                end else if (start) begin
                    quo_d  = '1;
                    rem_d  = x_q;
                    dbz_d  = 1'b1;
                    done_d = 1'b1;
                end
            end
            S_RUN: begin
                step = 1'b1;
                if (last) begin
                    state_d = S_IDLE;
                    quo_d   = core_quo;
                    rem_d   = core_rem;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        irq_d = done_d && ie_d;
    end

    // State and register update
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            ie_q    <= 1'b0;
            irq_q   <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            ie_q    <= ie_d;
            irq_q   <= irq_d;
            out_q   <= out_d;
        end
    end

    assign OUT = out_q;
    assign IRQ = irq_q;

endmodule

// File: tb/tb_xy_divide_seq.sv
// tb_xy_divide_seq: scoreboard bench for the divider peripheral against a cycle-level arithmetic model
module tb_xy_divide_seq;

    localparam int WIDTH = 16;
    localparam int OUT_W = 32;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             E = 1'b0, W = 1'b0, R = 1'b0;
    logic [1:0]       ADDR = 2'd0;
    logic [WIDTH-1:0] D = '0;
    logic [OUT_W-1:0] OUT;
    logic             IRQ;

    xy_divide_seq #(.WIDTH(WIDTH), .OUT_W(OUT_W)) dut (
        .CLK(CLK), .RST(RST), .E(E), .W(W), .R(R),
        .ADDR(ADDR), .D(D), .OUT(OUT), .IRQ(IRQ)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [OUT_W-1:0] out;
        logic             irq;
        int               id;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   nops  = 0;

    logic [WIDTH-1:0] mx, my, mquo, mrem, pq, pr;
    bit               mbusy, mdone, mdbz, mie;
    int               left;
    logic [OUT_W-1:0] mout;

    function automatic logic [OUT_W-1:0] rd_val(input logic [1:0] a);
        case (a)
            2'd0:    return OUT_W'(mx);
            2'd1:    return OUT_W'(my);
            2'd2:    return (OUT_W'(mrem) << WIDTH) | OUT_W'(mquo);
            default: return OUT_W'({mie, mdbz, mdone, mbusy});
        endcase
    endfunction

    task automatic model_reset();
        mx = '0; my = '0; mquo = '0; mrem = '0; pq = '0; pr = '0;
        mbusy = 0; mdone = 0; mdbz = 0; mie = 0; left = 0; mout = '0;
    endtask

    task automatic push_exp();
        exp_t x;
        x.out = mout;
        x.irq = mdone && mie;
        x.id  = nops++;
        q.push_back(x);
    endtask

    task automatic bus(input bit e, input bit w, input bit r, input logic [1:0] a, input logic [WIDTH-1:0] d);
        bit was_busy;
        @(negedge CLK);
        E = e; W = w; R = r; ADDR = a; D = d;
        if (e && r) mout = rd_val(a);
        was_busy = mbusy;
        if (e && w) begin
            if (a == 2'd0 && !was_busy) mx = d;
            if (a == 2'd1 && !was_busy) my = d;
            if (a == 2'd3) begin
                mie = d[2];
                if (d[1]) mdone = 0;
                if (d[0] && !was_busy) begin
                    if (my != 0) begin
                        mbusy = 1; mdone = 0; mdbz = 0;
                        pq = mx / my; pr = mx % my; left = WIDTH;
                    end else begin
                        mquo = '1; mrem = mx; mdbz = 1; mdone = 1;
                    end
                end
            end
        end
        if (was_busy) begin
            left--;
            if (left == 0) begin
                mbusy = 0; mdone = 1; mquo = pq; mrem = pr;
            end
        end
        push_exp();
        @(posedge CLK);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1; E = 0; W = 0; R = 0;
        model_reset();
        push_exp();
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic idle_reads(input int n, input logic [1:0] a);
        for (int i = 0; i < n; i++) bus(1, 0, 1, a, '0);
    endtask

    task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input bit ie);
        bus(1, 1, 0, 2'd0, x);
        bus(1, 1, 0, 2'd1, y);
        bus(1, 1, 0, 2'd3, WIDTH'({ie, 1'b0, 1'b1}));
        idle_reads(WIDTH + 1, 2'd3);
        bus(1, 0, 1, 2'd2, '0);
    endtask

    always @(posedge CLK) begin
        #1;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            total += 2;
            if (OUT !== mon_e.out) begin
                bad++;
                $display("FAIL out op=%0d got=%h exp=%h", mon_e.id, OUT, mon_e.out);
            end
            if (IRQ !== mon_e.irq) begin
                bad++;
                $display("FAIL irq op=%0d got=%b exp=%b", mon_e.id, IRQ, mon_e.irq);
            end
        end
    end

    initial begin
        logic [WIDTH-1:0] rx, ry;
        model_reset();
        do_reset();
        bus(1, 0, 1, 2'd3, '0);
        bus(1, 0, 1, 2'd2, '0);
        run_op(16'd100, 16'd7, 1);
        run_op(16'hFFFF, 16'd1, 0);
        run_op(16'd5, 16'd9, 1);
        bus(1, 1, 0, 2'd0, 16'd1234);
        bus(1, 1, 0, 2'd1, 16'd0);
        bus(1, 1, 0, 2'd3, 16'd1);
        idle_reads(2, 2'd3);
        bus(1, 0, 1, 2'd2, '0);
        run_op(16'd1000, 16'd3, 1);
        bus(1, 1, 0, 2'd3, 16'd5);
        idle_reads(3, 2'd3);
        bus(1, 1, 0, 2'd3, 16'd5);
        bus(1, 1, 0, 2'd0, 16'd3);
        bus(1, 1, 0, 2'd1, 16'd4);
        idle_reads(WIDTH, 2'd3);
        bus(1, 0, 1, 2'd2, '0);
        bus(1, 0, 1, 2'd0, '0);
        bus(1, 0, 1, 2'd1, '0);
        bus(1, 1, 0, 2'd3, 16'd5);
        idle_reads(8, 2'd3);
        do_reset();
        idle_reads(1, 2'd3);
        idle_reads(1, 2'd2);
        run_op(16'd200, 16'd10, 0);
        bus(0, 1, 1, 2'd0, 16'd4321);
        bus(0, 1, 1, 2'd3, 16'd7);
        bus(1, 0, 1, 2'd0, '0);
        bus(1, 1, 1, 2'd0, 16'd77);
        bus(1, 0, 1, 2'd0, '0);
        bus(1, 1, 0, 2'd1, 16'd5);
        bus(1, 1, 0, 2'd3, 16'd5);
        idle_reads(WIDTH - 1, 2'd1);
        bus(1, 1, 0, 2'd3, 16'd6);
        idle_reads(1, 2'd3);
        idle_reads(1, 2'd2);
        for (int k = 0; k < 40; k++) begin
            rx = WIDTH'($urandom);
            case ($urandom_range(3))
                0:       ry = '0;
                1:       ry = WIDTH'($urandom_range(1, 15));
                default: ry = WIDTH'($urandom);
            endcase
            bus(1, 1, 0, 2'd0, rx);
            bus(1, 1, 0, 2'd1, ry);
            bus(1, 1, 0, 2'd3, WIDTH'({$urandom_range(1), 2'b01}));
            for (int i = 0; i < WIDTH + 4; i++)
                bus(1'($urandom_range(1)), 1'($urandom_range(3) == 0), 1'($urandom_range(1)),
                    2'($urandom_range(3)), WIDTH'($urandom));
            bus(1, 0, 1, 2'd2, '0);
            bus(1, 0, 1, 2'd3, '0);
        end
        @(negedge CLK);
        E = 0; W = 0; R = 0;
        repeat (5) @(posedge CLK);
        #2;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d exp=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
